// File: rtl/spi_ram_arbiter.sv
// Arbitrates one single-port RAM between two 10-bit command requesters.
// A requester stays locked from its address command through its data command.
module spi_ram_arbiter #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 4
) (
    input  logic       SCK,
    input  logic       rst,
    input  logic [9:0] req0_data,
    input  logic       req0_valid,
    output logic       req0_ready,
    output logic [7:0] req0_tx_data,
    output logic       req0_tx_valid,
    input  logic [9:0] req1_data,
    input  logic       req1_valid,
    output logic       req1_ready,
    output logic [7:0] req1_tx_data,
    output logic       req1_tx_valid,
    output logic [9:0] ram_din,
    output logic       ram_rx_valid,
    input  logic [7:0] ram_dout,
    input  logic       ram_tx_valid,
    output logic [1:0] grant,
    output logic       rd_timeout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PASS    = 2'd1,
        RD_WAIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] TMAX = CNT_W'(TIMEOUT);

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [9:0]       ram_din_q, ram_din_d;
    logic             ram_rx_valid_q, ram_rx_valid_d;
    logic [7:0]       tx0_data_q, tx0_data_d;
    logic [7:0]       tx1_data_q, tx1_data_d;
    logic             tx0_valid_q, tx0_valid_d;
    logic             tx1_valid_q, tx1_valid_d;
    logic             rd_timeout_q, rd_timeout_d;

    logic             own_valid;
    logic [9:0]       own_data;
    logic             timer_max;
    logic [CNT_W-1:0] timer_inc;

    assign own_valid = owner_q ? req1_valid : req0_valid;
    assign own_data  = owner_q ? req1_data  : req0_data;
    assign timer_max = (timer_q == TMAX);
    // Saturating increment: the counter parks at TIMEOUT instead of wrapping.
    assign timer_inc = timer_max ? timer_q : timer_q + 1'b1;

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        timer_d        = timer_q;
        ram_din_d      = ram_din_q;
        ram_rx_valid_d = 1'b0;
        tx0_data_d     = tx0_data_q;
        tx1_data_d     = tx1_data_q;
        tx0_valid_d    = 1'b0;
        tx1_valid_d    = 1'b0;
        rd_timeout_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    if (req0_valid && req1_valid) begin
                        owner_d = ~last_q;
                    end else begin
                        owner_d = req1_valid;
                    end
                    state_d = PASS;
                    timer_d = '0;
                end
            end
            PASS: begin
                if (own_valid) begin
                    ram_din_d      = own_data;
                    ram_rx_valid_d = 1'b1;
                    timer_d        = '0;
                    unique case (own_data[9:8])
                        2'b01: begin
                            state_d = IDLE;
                            last_d  = owner_q;
                        end
                        2'b11:   state_d = RD_WAIT;
                        default: state_d = PASS;
                    endcase
                end else if (timer_max) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else begin
                    timer_d = timer_inc;
                end
            end
            RD_WAIT: begin
                if (ram_tx_valid) begin
                    if (owner_q) begin
                        tx1_data_d  = ram_dout;
                        tx1_valid_d = 1'b1;
                    end else begin
                        tx0_data_d  = ram_dout;
                        tx0_valid_d = 1'b1;
                    end
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (timer_max) begin
                    rd_timeout_d = 1'b1;
                    state_d      = IDLE;
                    last_d       = owner_q;
                end else begin
                    timer_d = timer_inc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge SCK) begin
        if (rst) begin
            state_q        <= IDLE;
            owner_q        <= 1'b0;
            last_q         <= 1'b1;
            timer_q        <= '0;
            ram_din_q      <= '0;
            ram_rx_valid_q <= 1'b0;
            tx0_data_q     <= '0;
            tx1_data_q     <= '0;
            tx0_valid_q    <= 1'b0;
            tx1_valid_q    <= 1'b0;
            rd_timeout_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_q         <= last_d;
            timer_q        <= timer_d;
            ram_din_q      <= ram_din_d;
            ram_rx_valid_q <= ram_rx_valid_d;
            tx0_data_q     <= tx0_data_d;
            tx1_data_q     <= tx1_data_d;
            tx0_valid_q    <= tx0_valid_d;
            tx1_valid_q    <= tx1_valid_d;
            rd_timeout_q   <= rd_timeout_d;
        end
    end

    assign req0_ready    = (state_q == PASS) && !owner_q && req0_valid;
    assign req1_ready    = (state_q == PASS) &&  owner_q && req1_valid;
    assign grant[0]      = (state_q != IDLE) && !owner_q;
    assign grant[1]      = (state_q != IDLE) &&  owner_q;
    assign ram_din       = ram_din_q;
    assign ram_rx_valid  = ram_rx_valid_q;
    assign req0_tx_data  = tx0_data_q;
    assign req1_tx_data  = tx1_data_q;
    assign req0_tx_valid = tx0_valid_q;
    assign req1_tx_valid = tx1_valid_q;
    assign rd_timeout    = rd_timeout_q;

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: directed scenarios, a session-level reference
// model checked every cycle, and literal expectations per scenario.
module tb_spi_ram_arbiter;

    localparam int TO = 15;

    logic       SCK = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] req0_data = '0;
    logic       req0_valid = 1'b0;
    logic       req0_ready;
    logic [7:0] req0_tx_data;
    logic       req0_tx_valid;
    logic [9:0] req1_data = '0;
    logic       req1_valid = 1'b0;
    logic       req1_ready;
    logic [7:0] req1_tx_data;
    logic       req1_tx_valid;
    logic [9:0] ram_din;
    logic       ram_rx_valid;
    logic [7:0] ram_dout = '0;
    logic       ram_tx_valid = 1'b0;
    logic [1:0] grant;
    logic       rd_timeout;

    spi_ram_arbiter dut (
        .SCK          (SCK),
        .rst          (rst),
        .req0_data    (req0_data),
        .req0_valid   (req0_valid),
        .req0_ready   (req0_ready),
        .req0_tx_data (req0_tx_data),
        .req0_tx_valid(req0_tx_valid),
        .req1_data    (req1_data),
        .req1_valid   (req1_valid),
        .req1_ready   (req1_ready),
        .req1_tx_data (req1_tx_data),
        .req1_tx_valid(req1_tx_valid),
        .ram_din      (ram_din),
        .ram_rx_valid (ram_rx_valid),
        .ram_dout     (ram_dout),
        .ram_tx_valid (ram_tx_valid),
        .grant        (grant),
        .rd_timeout   (rd_timeout)
    );

    always #5 SCK = ~SCK;

    int total = 0;
    int bad = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge SCK);
        #1;
    endtask

    // Session model: owner (-1 = nobody), whether a read is outstanding,
    // idle cycles seen, last served requester, and expected output values.
    int         m_owner = -1;
    bit         m_reading = 1'b0;
    int         m_idle = 0;
    int         m_last = 1;
    logic [9:0] e_din = '0;
    bit         e_rx = 1'b0;
    logic [7:0] e_txd [2] = '{8'h00, 8'h00};
    bit         e_txv [2] = '{1'b0, 1'b0};
    bit         e_to = 1'b0;

    always @(posedge SCK) begin
        bit         v [2];
        logic [9:0] d [2];
        v[0] = req0_valid;
        v[1] = req1_valid;
        d[0] = req0_data;
        d[1] = req1_data;
        e_rx = 1'b0;
        e_txv[0] = 1'b0;
        e_txv[1] = 1'b0;
        e_to = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_reading = 1'b0;
            m_idle = 0;
            m_last = 1;
            e_din = '0;
            e_txd[0] = '0;
            e_txd[1] = '0;
        end else if (m_owner < 0) begin
            if (v[0] || v[1]) begin
                m_owner = (v[0] && v[1]) ? 1 - m_last : (v[0] ? 0 : 1);
                m_idle = 0;
            end
        end else if (!m_reading) begin
            if (v[m_owner]) begin
                e_din = d[m_owner];
                e_rx = 1'b1;
                m_idle = 0;
                if (d[m_owner][9:8] == 2'b01) begin
                    m_last = m_owner;
                    m_owner = -1;
                end else if (d[m_owner][9:8] == 2'b11) begin
                    m_reading = 1'b1;
                end
            end else if (m_idle >= TO) begin
                m_last = m_owner;
                m_owner = -1;
            end else begin
                m_idle++;
            end
        end else begin
            if (ram_tx_valid) begin
                e_txd[m_owner] = ram_dout;
                e_txv[m_owner] = 1'b1;
                m_last = m_owner;
                m_owner = -1;
                m_reading = 1'b0;
            end else if (m_idle >= TO) begin
                e_to = 1'b1;
                m_last = m_owner;
                m_owner = -1;
                m_reading = 1'b0;
            end else begin
                m_idle++;
            end
        end
    end

    always @(negedge SCK) begin
        if (chk_on) begin
            chk("grant", grant, m_owner < 0 ? 0 : (m_owner == 0 ? 1 : 2));
            chk("req0_ready", req0_ready,
                (m_owner == 0 && !m_reading && req0_valid) ? 1 : 0);
            chk("req1_ready", req1_ready,
                (m_owner == 1 && !m_reading && req1_valid) ? 1 : 0);
            chk("ram_din", ram_din, e_din);
            chk("ram_rx_valid", ram_rx_valid, e_rx);
            chk("req0_tx_data", req0_tx_data, e_txd[0]);
            chk("req1_tx_data", req1_tx_data, e_txd[1]);
            chk("req0_tx_valid", req0_tx_valid, e_txv[0]);
            chk("req1_tx_valid", req1_tx_valid, e_txv[1]);
            chk("rd_timeout", rd_timeout, e_to);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int pulses;
        int txp;
        bit r0;
        bit r1;
        logic [1:0] prev_g;
        logic [9:0] q0 [$];
        logic [9:0] q1 [$];
        logic [9:0] dins [$];
        logic [1:0] grants [$];
        logic [9:0] exp_din [8] = '{10'h011, 10'h1AA, 10'h033, 10'h1CC,
                                     10'h022, 10'h1BB, 10'h044, 10'h1DD};
        logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

        tick();
        chk_on = 1'b1;
        tick();
        chk("rst_grant", grant, 0);
        chk("rst_din", ram_din, 0);
        chk("rst_timeout", rd_timeout, 0);
        rst = 1'b0;

        // 1: write address then write data from req0
        req0_valid = 1'b1;
        req0_data = 10'h005;
        tick();
        chk("t1_grant", grant, 2'b01);
        chk("t1_ready", req0_ready, 1);
        tick();
        chk("t1_din0", ram_din, 10'h005);
        chk("t1_rx0", ram_rx_valid, 1);
        req0_data = 10'h1A5;
        tick();
        chk("t1_din1", ram_din, 10'h1A5);
        chk("t1_idle", grant, 2'b00);
        req0_valid = 1'b0;
        tick();
        chk("t1_rx_end", ram_rx_valid, 0);

        // 2: both valid from reset, req0 performs a read
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0_valid = 1'b1;
        req0_data = 10'h205;
        req1_valid = 1'b1;
        req1_data = 10'h010;
        tick();
        chk("t2_grant0", grant, 2'b01);
        chk("t2_rdy1", req1_ready, 0);
        tick();
        chk("t2_din_addr", ram_din, 10'h205);
        req0_data = 10'h300;
        tick();
        chk("t2_din_rd", ram_din, 10'h300);
        req0_valid = 1'b0;
        ram_tx_valid = 1'b1;
        ram_dout = 8'hA5;
        tick();
        ram_tx_valid = 1'b0;
        chk("t2_txv0", req0_tx_valid, 1);
        chk("t2_txd0", req0_tx_data, 8'hA5);
        chk("t2_txv1", req1_tx_valid, 0);
        tick();
        chk("t2_grant1", grant, 2'b10);
        tick();
        chk("t2_din_req1", ram_din, 10'h010);

        // 3: req1 goes silent while locked, req0 waits
        req1_data = 10'h033;
        tick();
        chk("t3_din", ram_din, 10'h033);
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_data = 10'h111;
        n = 0;
        pulses = 0;
        while (grant != 2'b00 && n < 40) begin
            tick();
            n++;
            if (rd_timeout) pulses++;
        end
        chk("t3_release_cycles", n, TO + 1);
        chk("t3_no_timeout", pulses, 0);
        tick();
        chk("t3_grant0", grant, 2'b01);
        tick();
        chk("t3_din0", ram_din, 10'h111);
        req0_valid = 1'b0;

        // 4: read data never returns
        tick();
        req0_valid = 1'b1;
        req0_data = 10'h3FF;
        tick();
        tick();
        chk("t4_din", ram_din, 10'h3FF);
        req0_valid = 1'b0;
        n = 0;
        txp = 0;
        while (!rd_timeout && n < 40) begin
            tick();
            n++;
            txp += int'(req0_tx_valid);
        end
        chk("t4_timeout_cycles", n, TO + 1);
        chk("t4_idle", grant, 2'b00);
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            pulses += int'(rd_timeout);
            txp += int'(req0_tx_valid);
        end
        chk("t4_single_pulse", pulses, 0);
        chk("t4_no_txv", txp, 0);

        // 5: reset during RD_WAIT, late RAM data, then 6: alternating pairs
        req0_valid = 1'b1;
        req0_data = 10'h300;
        tick();
        tick();
        req0_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("t5_grant", grant, 0);
        chk("t5_din", ram_din, 0);
        chk("t5_txd0", req0_tx_data, 0);
        chk("t5_rx", ram_rx_valid, 0);
        rst = 1'b0;
        ram_dout = 8'h5A;
        q0 = '{10'h011, 10'h1AA, 10'h022, 10'h1BB};
        q1 = '{10'h033, 10'h1CC, 10'h044, 10'h1DD};
        prev_g = 2'b00;
        txp = 0;
        n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < 80) begin
            ram_tx_valid = (n == 0);
            req0_valid = (q0.size() > 0);
            req0_data = (q0.size() > 0) ? q0[0] : 10'h000;
            req1_valid = (q1.size() > 0);
            req1_data = (q1.size() > 0) ? q1[0] : 10'h000;
            #1;
            r0 = req0_ready;
            r1 = req1_ready;
            tick();
            if (r0) void'(q0.pop_front());
            if (r1) void'(q1.pop_front());
            if (ram_rx_valid) dins.push_back(ram_din);
            if (grant != prev_g && grant != 2'b00) grants.push_back(grant);
            prev_g = grant;
            txp += int'(req0_tx_valid) + int'(req1_tx_valid);
            n++;
        end
        ram_tx_valid = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
        tick();
        chk("t5_no_txv", txp, 0);
        chk("t6_words", dins.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < dins.size()) chk("t6_order", dins[i], exp_din[i]);
        end
        chk("t6_grants", grants.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < grants.size()) chk("t6_grant_seq", grants[i], exp_g[i]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
